ram_arbiter: RTL and testbench

- Shares the single-port data RAM between three requesters: the CPU control unit (loads/stores), the video fetch unit (burst reads) and the serial program loader (single writes).
- The CPU has fixed top priority. A starvation counter guarantees the two low-priority masters a slot; video and loader alternate round-robin between themselves.
- Sits between the control unit's RAM interface and the RAM macro. Memory is 1-cycle synchronous read, 16-bit address, 16-bit data.

---
 rtl/ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - three-master arbiter for the single-port data RAM
// CPU has fixed priority; video bursts and loader writes share round-robin slots with a starvation guard.
module ram_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int ADD_W    = 16,
    parameter int DATA_W   = 16
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              cpuReq,
    input  logic              cpuWrite,
    input  logic [ADD_W-1:0]  cpuAdd,
    input  logic [DATA_W-1:0] cpuDin,
    output logic              cpuStall,
    output logic              cpuValid,

    input  logic              vidReq,
    input  logic [ADD_W-1:0]  vidAdd,
    input  logic [3:0]        vidLen,
    output logic              vidGnt,
    output logic              vidValid,
    output logic              vidDone,

    input  logic              ldReq,
    input  logic [ADD_W-1:0]  ldAdd,
    input  logic [DATA_W-1:0] ldDin,
    output logic              ldGnt,

    output logic [ADD_W-1:0]  ramAdd,
    output logic [DATA_W-1:0] ramDin,
    output logic              ramWrite,
    input  logic [DATA_W-1:0] ramDout,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_wait_cnt;
    logic [3:0]         w_wait_nxt;
    logic               r_rr_ptr;
    logic               w_rr_nxt;
    logic [3:0]         r_remaining;
    logic [3:0]         w_remaining_nxt;
    logic [ADD_W-1:0]   r_next_add;
    logic [ADD_W-1:0]   w_next_add_nxt;

    logic               r_cpu_valid;
    logic               r_vid_valid;
    logic               r_vid_done;

    logic               w_low_pend;
    logic               w_starve;
    logic               w_pick_vid;
    logic               w_serve_cpu;
    logic               w_serve_vid;
    logic               w_serve_ld;
    logic               w_beat;
    logic               w_last_beat;

    // During a burst the video request is ignored, so only the loader can be pending.
    assign w_low_pend  = (r_state == S_BURST) ? ldReq : (vidReq | ldReq);
    assign w_starve    = (r_wait_cnt == WAIT_MAX) & w_low_pend;
    assign w_pick_vid  = r_rr_ptr ? ~ldReq : vidReq;
    assign w_last_beat = (r_remaining == 4'd1);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_rr_ptr    <= 1'b0;
            r_remaining <= 4'd0;
            r_next_add  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_remaining <= w_remaining_nxt;
            r_next_add  <= w_next_add_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_nxt      = r_wait_cnt;
        w_rr_nxt        = r_rr_ptr;
        w_remaining_nxt = r_remaining;
        w_next_add_nxt  = r_next_add;
        w_serve_cpu     = 1'b0;
        w_serve_vid     = 1'b0;
        w_serve_ld      = 1'b0;
        w_beat          = 1'b0;
        cpuStall        = 1'b0;
        vidGnt          = 1'b0;
        ldGnt           = 1'b0;
        ramAdd          = '0;
        ramDin          = '0;
        ramWrite        = 1'b0;

        if (RST_N) begin
            case (r_state)
                S_IDLE: begin
                    if (w_starve || (!cpuReq && w_low_pend)) begin
                        w_serve_vid = w_pick_vid;
                        w_serve_ld  = ~w_pick_vid;
                        cpuStall    = cpuReq;
                    end else if (cpuReq) begin
                        w_serve_cpu = 1'b1;
                    end
                end
                S_BURST: begin
                    w_beat   = 1'b1;
                    cpuStall = cpuReq;
                end
                default: w_state_nxt = S_IDLE;
            endcase

            if (w_serve_cpu) begin
                ramAdd   = cpuAdd;
                ramDin   = cpuDin;
                ramWrite = cpuWrite;
            end

            if (w_serve_ld) begin
                ramAdd   = ldAdd;
                ramDin   = ldDin;
                ramWrite = 1'b1;
                ldGnt    = 1'b1;
            end

            if (w_serve_vid) begin
                ramAdd = vidAdd;
                vidGnt = 1'b1;
                if (vidLen != 4'd0) begin
                    w_state_nxt     = S_BURST;
                    w_remaining_nxt = vidLen;
                    w_next_add_nxt  = vidAdd + ADD_W'(1);
                end
            end

            if (w_beat) begin
                ramAdd          = r_next_add;
                w_next_add_nxt  = r_next_add + ADD_W'(1);
                w_remaining_nxt = r_remaining - 4'd1;
                if (w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end

            if (w_serve_vid || w_serve_ld) begin
                w_wait_nxt = 4'd0;
                w_rr_nxt   = ~r_rr_ptr;
            end else if (w_low_pend) begin
                w_wait_nxt = (r_wait_cnt == WAIT_MAX) ? WAIT_MAX : r_wait_cnt + 4'd1;
            end else begin
                w_wait_nxt = 4'd0;
            end
        end
    end

    // Read-return flags track the access issued in the previous cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cpu_valid <= 1'b0;
            r_vid_valid <= 1'b0;
            r_vid_done  <= 1'b0;
        end else begin
            r_cpu_valid <= w_serve_cpu & ~cpuWrite;
            r_vid_valid <= w_serve_vid | w_beat;
            r_vid_done  <= (w_serve_vid & (vidLen == 4'd0)) | (w_beat & w_last_beat);
        end
    end

    assign cpuValid = r_cpu_valid;
    assign vidValid = r_vid_valid;
    assign vidDone  = r_vid_done;
    assign rdata    = ramDout;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter against a queue-based reference model
module tb_ram_arbiter;
    localparam int MW = 8;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        cpuReq, cpuWrite, cpuStall, cpuValid;
    logic [15:0] cpuAdd, cpuDin;
    logic        vidReq, vidGnt, vidValid, vidDone;
    logic [15:0] vidAdd;
    logic [3:0]  vidLen;
    logic        ldReq, ldGnt;
    logic [15:0] ldAdd, ldDin;
    logic [15:0] ramAdd, ramDin, ramDout, rdata;
    logic        ramWrite;

    ram_arbiter #(.MAX_WAIT(MW), .ADD_W(16), .DATA_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAdd(cpuAdd), .cpuDin(cpuDin),
        .cpuStall(cpuStall), .cpuValid(cpuValid),
        .vidReq(vidReq), .vidAdd(vidAdd), .vidLen(vidLen), .vidGnt(vidGnt),
        .vidValid(vidValid), .vidDone(vidDone),
        .ldReq(ldReq), .ldAdd(ldAdd), .ldDin(ldDin), .ldGnt(ldGnt),
        .ramAdd(ramAdd), .ramDin(ramDin), .ramWrite(ramWrite), .ramDout(ramDout),
        .rdata(rdata)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [0:65535];
    always @(posedge CLK) begin
        ramDout <= mem[ramAdd];
        if (ramWrite) mem[ramAdd] <= ramDin;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending burst beats are a queue of addresses.
    int          m_wait;
    bit          m_rr;
    logic [15:0] q_burst [$];
    bit          m_rv_cpu, m_rv_vid, m_rv_done;
    logic [15:0] m_rdata;
    logic [15:0] ref_mem [int];

    logic        e_stall, e_vgnt, e_lgnt, e_wr, e_last;
    logic [15:0] e_add, e_din;
    int          e_kind; // 0 none, 1 cpu read, 2 cpu write, 3 video read, 4 loader write

    logic [54:0] obs, exp;

    function automatic logic [15:0] init_val(int a);
        return 16'((a * 40503) ^ 23130);
    endfunction

    function automatic logic [15:0] ref_rd(logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(int'(a));
    endfunction

    task automatic model_expect();
        bit lp, starve, first_is_ld, take_ld;
        e_stall = 0; e_vgnt = 0; e_lgnt = 0; e_wr = 0; e_last = 0;
        e_add = 0; e_din = 0; e_kind = 0;
        if (RST_N !== 1'b1) return;
        if (q_burst.size() > 0) begin
            e_kind  = 3;
            e_add   = q_burst[0];
            e_last  = (q_burst.size() == 1);
            e_stall = cpuReq;
            return;
        end
        lp     = vidReq | ldReq;
        starve = lp && (m_wait == MW);
        if (starve || (!cpuReq && lp)) begin
            first_is_ld = m_rr;
            take_ld     = first_is_ld ? ldReq : !vidReq;
            e_stall     = cpuReq;
            if (take_ld) begin
                e_kind = 4; e_add = ldAdd; e_din = ldDin; e_wr = 1; e_lgnt = 1;
            end else begin
                e_kind = 3; e_add = vidAdd; e_vgnt = 1; e_last = (vidLen == 0);
            end
        end else if (cpuReq) begin
            e_kind = cpuWrite ? 2 : 1;
            e_add  = cpuAdd;
            e_din  = cpuDin;
            e_wr   = cpuWrite;
        end
    endtask

    task automatic model_advance();
        bit in_burst, low;
        if (RST_N !== 1'b1) begin
            m_wait = 0; m_rr = 0; q_burst.delete();
            m_rv_cpu = 0; m_rv_vid = 0; m_rv_done = 0;
            return;
        end
        m_rv_cpu  = (e_kind == 1);
        m_rv_vid  = (e_kind == 3);
        m_rv_done = (e_kind == 3) && e_last;
        if (e_kind == 1 || e_kind == 3) m_rdata = ref_rd(e_add);
        if (e_kind == 2 || e_kind == 4) ref_mem[int'(e_add)] = e_din;
        in_burst = (q_burst.size() > 0);
        if (in_burst) void'(q_burst.pop_front());
        else if (e_vgnt) for (int i = 1; i <= int'(vidLen); i++) q_burst.push_back(16'(int'(vidAdd) + i));
        low = in_burst ? ldReq : (vidReq | ldReq);
        if (e_vgnt || e_lgnt) begin
            m_wait = 0; m_rr = !m_rr;
        end else if (low) begin
            m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        end else begin
            m_wait = 0;
        end
    endtask

    function automatic logic [54:0] pack_obs();
        return {cpuStall, vidGnt, ldGnt, ramWrite, ramAdd, (e_wr ? ramDin : 16'h0),
                cpuValid, vidValid, vidDone, ((m_rv_cpu || m_rv_vid) ? rdata : 16'h0)};
    endfunction

    function automatic logic [54:0] pack_exp();
        return {e_stall, e_vgnt, e_lgnt, e_wr, e_add, (e_wr ? e_din : 16'h0),
                m_rv_cpu, m_rv_vid, m_rv_done, ((m_rv_cpu || m_rv_vid) ? m_rdata : 16'h0)};
    endfunction

    task automatic clear_inputs();
        cpuReq = 0; cpuWrite = 0; cpuAdd = 0; cpuDin = 0;
        vidReq = 0; vidAdd = 0; vidLen = 0;
        ldReq = 0; ldAdd = 0; ldDin = 0;
    endtask

    task automatic apply_reset();
        RST_N = 0;
        clear_inputs();
        #1; model_expect(); model_advance();
        @(posedge CLK); #1;
        RST_N = 1;
    endtask

    task automatic test_reset();
        RST_N = 0;
        for (int c = 0; c < 4; c++) begin
            cpuReq = 1'($urandom); cpuWrite = 1'($urandom); cpuAdd = 16'($urandom); cpuDin = 16'($urandom);
            vidReq = 1'($urandom); vidAdd = 16'($urandom); vidLen = 4'($urandom);
            ldReq = 1'($urandom); ldAdd = 16'($urandom); ldDin = 16'($urandom);
            #1; model_expect(); obs = pack_obs(); exp = pack_exp();
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL reset cyc %0d: got %h want %h", c, obs, exp); end
            model_advance(); @(posedge CLK); #1;
        end
        RST_N = 1;
    endtask

    task automatic test_cpu_only();
        apply_reset();
        mem[16'h0040] = 16'hBEEF; ref_mem[32'h40] = 16'hBEEF;
        cpuReq = 1; cpuWrite = 0; cpuAdd = 16'h0040;
        #1;
        n_checks++;
        if (cpuStall !== 1'b0 || ramAdd !== 16'h0040) begin
            n_fail++; $display("FAIL cpu_issue: stall=%b add=%h want stall=0 add=0040", cpuStall, ramAdd);
        end
        model_expect(); model_advance(); @(posedge CLK); #1;
        cpuReq = 0;
        #1;
        n_checks++;
        if (cpuValid !== 1'b1 || rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL cpu_return: valid=%b rdata=%h want valid=1 rdata=beef", cpuValid, rdata);
        end
        model_expect(); model_advance(); @(posedge CLK); #1;
        for (int c = 0; c < 30; c++) begin
            cpuReq = 1'($urandom); cpuWrite = 1'($urandom);
            cpuAdd = 16'h0040 + 16'($urandom_range(0, 7)); cpuDin = 16'($urandom);
            #1; model_expect(); obs = pack_obs(); exp = pack_exp();
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL cpu_random cyc %0d: got %h want %h", c, obs, exp); end
            model_advance(); @(posedge CLK); #1;
        end
        cpuReq = 0;
    endtask

    task automatic test_starvation();
        int first_ld = -1;
        logic stall9 = 1'bx;
        apply_reset();
        cpuReq = 1; cpuWrite = 0; cpuAdd = 16'h0200;
        ldReq = 1; ldAdd = 16'h0100; ldDin = 16'h1234;
        for (int c = 0; c < 12; c++) begin
            #1; model_expect(); obs = pack_obs(); exp = pack_exp();
            if (ldGnt === 1'b1 && first_ld < 0) first_ld = c;
            if (c == 9) stall9 = cpuStall;
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL starve cyc %0d: got %h want %h", c, obs, exp); end
            model_advance(); @(posedge CLK); #1;
            if (e_lgnt) ldReq = 0;
            cpuAdd = cpuAdd + 16'h1;
        end
        n_checks++;
        if (first_ld != 8) begin n_fail++; $display("FAIL starve_slot: loader granted cyc %0d want 8", first_ld); end
        n_checks++;
        if (stall9 !== 1'b0) begin n_fail++; $display("FAIL starve_resume: cyc9 stall=%b want 0", stall9); end
        clear_inputs();
    endtask

    task automatic test_burst();
        logic [6:0] vmask = '0, dmask = '0;
        logic [15:0] adds [4];
        apply_reset();
        vidReq = 1; vidAdd = 16'h2000; vidLen = 4'd3;
        for (int c = 0; c < 7; c++) begin
            #1; model_expect(); obs = pack_obs(); exp = pack_exp();
            vmask[c] = vidValid; dmask[c] = vidDone;
            if (c < 4) adds[c] = ramAdd;
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL burst cyc %0d: got %h want %h", c, obs, exp); end
            model_advance(); @(posedge CLK); #1;
            vidReq = 0;
        end
        n_checks++;
        if (adds[0] !== 16'h2000 || adds[1] !== 16'h2001 || adds[2] !== 16'h2002 || adds[3] !== 16'h2003) begin
            n_fail++; $display("FAIL burst_addr: got %h %h %h %h want 2000..2003", adds[0], adds[1], adds[2], adds[3]);
        end
        n_checks++;
        if (vmask !== 7'b0011110 || dmask !== 7'b0010000) begin
            n_fail++; $display("FAIL burst_flags: valid=%b done=%b want 0011110 0010000", vmask, dmask);
        end
    endtask

    task automatic test_wrap();
        int first_cpu = -1;
        logic [15:0] adds [3];
        apply_reset();
        vidReq = 1; vidAdd = 16'hFFFE; vidLen = 4'd2;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin cpuReq = 1; cpuWrite = 0; cpuAdd = 16'h0055; end
            #1; model_expect(); obs = pack_obs(); exp = pack_exp();
            if (c < 3) adds[c] = ramAdd;
            if (cpuReq && cpuStall === 1'b0 && first_cpu < 0) first_cpu = c;
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL wrap cyc %0d: got %h want %h", c, obs, exp); end
            model_advance(); @(posedge CLK); #1;
            vidReq = 0;
            if (cpuReq && !e_stall) cpuReq = 0;
        end
        n_checks++;
        if (adds[0] !== 16'hFFFE || adds[1] !== 16'hFFFF || adds[2] !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_addr: got %h %h %h want fffe ffff 0000", adds[0], adds[1], adds[2]);
        end
        n_checks++;
        if (first_cpu != 3) begin n_fail++; $display("FAIL wrap_cpu: served cyc %0d want 3", first_cpu); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [3:0] order = '0;
        int grants = 0;
        apply_reset();
        vidReq = 1; vidLen = 0; vidAdd = 16'h3000;
        ldReq = 1; ldAdd = 16'h3100;
        for (int c = 0; c < 4; c++) begin
            ldDin = 16'($urandom);
            #1; model_expect(); obs = pack_obs(); exp = pack_exp();
            if (ldGnt === 1'b1) order[c] = 1'b1;
            if ((vidGnt ^ ldGnt) === 1'b1) grants++;
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL rr cyc %0d: got %h want %h", c, obs, exp); end
            model_advance(); @(posedge CLK); #1;
        end
        n_checks++;
        if (order !== 4'b1010 || grants != 4) begin
            n_fail++; $display("FAIL rr_order: got %b (%0d grants) want 1010 (4 grants)", order, grants);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        int dones = 0;
        logic [20:0] after_rst;
        apply_reset();
        vidReq = 1; vidAdd = 16'h4000; vidLen = 4'd7;
        for (int c = 0; c < 10; c++) begin
            RST_N = (c == 2) ? 1'b0 : 1'b1;
            if (c == 4) begin cpuReq = 1; cpuWrite = 0; cpuAdd = 16'h4003; end
            #1; model_expect(); obs = pack_obs(); exp = pack_exp();
            if (vidDone === 1'b1) dones++;
            if (c == 3) after_rst = {cpuStall, vidGnt, ldGnt, ramWrite, cpuValid, vidValid, vidDone, ramAdd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            if (c == 4) begin
                n_checks++;
                if (cpuStall !== 1'b0 || ramAdd !== 16'h4003) begin
                    n_fail++; $display("FAIL rst_first_req: stall=%b add=%h want 0 4003", cpuStall, ramAdd);
                end
            end
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL rst_burst cyc %0d: got %h want %h", c, obs, exp); end
            model_advance(); @(posedge CLK); #1;
            vidReq = 0;
            if (c == 4) cpuReq = 0;
        end
        RST_N = 1;
        n_checks++;
        if (after_rst !== 21'h0) begin n_fail++; $display("FAIL rst_outputs: got %h want 0", after_rst); end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL rst_done: saw %0d vidDone want 0", dones); end
        clear_inputs();
    endtask

    task automatic test_random();
        bit keep_cpu, keep_vid, keep_ld;
        for (int c = 0; c < 1500; c++) begin
            keep_cpu = cpuReq && e_stall;
            keep_vid = vidReq && !e_vgnt;
            keep_ld  = ldReq && !e_lgnt;
            RST_N = ($urandom_range(0, 299) != 0);
            if (!keep_cpu) begin
                cpuReq = ($urandom_range(0, 99) < 60); cpuWrite = 1'($urandom);
                cpuAdd = 16'h5000 + 16'($urandom_range(0, 15)); cpuDin = 16'($urandom);
            end
            if (!keep_vid) begin
                vidReq = ($urandom_range(0, 99) < 20);
                vidAdd = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'h5000 + 16'($urandom_range(0, 15));
                vidLen = 4'($urandom);
            end
            if (!keep_ld) begin
                ldReq = ($urandom_range(0, 99) < 25);
                ldAdd = 16'h5000 + 16'($urandom_range(0, 15)); ldDin = 16'($urandom);
            end
            #1; model_expect(); obs = pack_obs(); exp = pack_exp();
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL random cyc %0d: got %h want %h", c, obs, exp); end
            model_advance(); @(posedge CLK); #1;
        end
        RST_N = 1;
        clear_inputs();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = init_val(a);
        m_wait = 0; m_rr = 0; m_rv_cpu = 0; m_rv_vid = 0; m_rv_done = 0; m_rdata = 0;
        e_stall = 0; e_vgnt = 0; e_lgnt = 0; e_wr = 0; e_last = 0; e_add = 0; e_din = 0; e_kind = 0;
        RST_N = 0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_cpu_only();
        test_starvation();
        test_burst();
        test_wrap();
        test_round_robin();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
